ask_tx_controller: RTL

Frame sequencer for the ASK modulator datapath (lfsr -> word_generator -> xor_word).
- Seeds the modulator through its reset and load controls, then steps it at the bit rate through a clock-enable.
- Builds the transmitted frame: preamble, sync word, n_words scrambled 12-bit payload words, then a guard interval.
- Produces the on/off-keyed carrier ask_out. Sits between the transmit top level and the modulator instance.

---
 rtl/ask_pkg.sv | 28 ++
 rtl/ask_bit_timer.sv | 56 +++++
 rtl/ask_tx_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ask_pkg.sv
// Shared types and frame constants for the ASK transmit sequencer.
// WORD_W is the scrambled word width produced by the modulator datapath.
package ask_pkg;

    localparam int WORD_W = 12;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEF     = 12'hB4F;
    localparam int                PREAMBLE_BITS_DEF = 16;
    localparam int                GUARD_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_LOAD,
        ST_PREAMBLE,
        ST_SYNC,
        ST_ALIGN,
        ST_PAYLOAD,
        ST_GUARD
    } ask_state_e;

    // States in which the bit-period counter runs.
    function automatic logic is_bit_state(input ask_state_e s);
        return (s == ST_PREAMBLE) || (s == ST_SYNC) || (s == ST_ALIGN) ||
               (s == ST_PAYLOAD)  || (s == ST_GUARD);
    endfunction

endpackage

// File: rtl/ask_bit_timer.sv
// Bit-period counter and carrier divider for the ASK transmitter.
// bit_start/bit_end mark the first and last clock of each bit period.
module ask_bit_timer #(
    parameter int SPB          = 16,
    parameter int CARRIER_HALF = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bit_clr_i,
    input  logic car_clr_i,
    output logic bit_start_o,
    output logic bit_end_o,
    output logic carrier_o
);

    localparam int BW = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] car_cnt_q, car_cnt_d;
    logic          carrier_q, carrier_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_clr_i || (bit_cnt_q == BW'(SPB - 1))) begin
            bit_cnt_d = '0;
        end

        car_cnt_d = car_cnt_q + CW'(1);
        carrier_d = carrier_q;
        if (car_clr_i) begin
            car_cnt_d = '0;
            carrier_d = 1'b0;
        end else if (car_cnt_q == CW'(CARRIER_HALF - 1)) begin
            car_cnt_d = '0;
            carrier_d = ~carrier_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
            car_cnt_q <= '0;
            carrier_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            car_cnt_q <= car_cnt_d;
            carrier_q <= carrier_d;
        end
    end

    assign bit_start_o = (bit_cnt_q == '0);
    assign bit_end_o   = (bit_cnt_q == BW'(SPB - 1));
    assign carrier_o   = carrier_q;

endmodule

// File: rtl/ask_tx_controller.sv
// Frame sequencer for the ASK modulator: seeds and steps the modulator and
// emits preamble, sync, scrambled payload words and guard as on/off keying.
module ask_tx_controller
    import ask_pkg::*;
#(
    parameter int                SPB           = 16,
    parameter int                CARRIER_HALF  = 2,
    parameter int                PREAMBLE_BITS = PREAMBLE_BITS_DEF,
    parameter logic [WORD_W-1:0] SYNC_WORD     = SYNC_WORD_DEF,
    parameter int                GUARD_BITS    = GUARD_BITS_DEF,
    parameter int                CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_words,
    input  logic             mod_bit,
    input  logic             mod_new_word,
    output logic             mod_rst,
    output logic             mod_load,
    output logic             mod_ce,
    output logic             tx_bit,
    output logic             ask_out,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int MAX_PW  = (PREAMBLE_BITS > WORD_W) ? PREAMBLE_BITS : WORD_W;
    localparam int IDX_MAX = (GUARD_BITS > MAX_PW) ? GUARD_BITS : MAX_PW;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    ask_state_e       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] n_words_q, n_words_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             seen_q, seen_d;
    logic             tx_q, tx_d;
    logic             ask_q;
    logic             mod_rst_q;

    logic             bit_start;
    logic             bit_end;
    logic             carrier;
    logic [WORD_W-1:0] sync_shift;

    // Bit counter restarts on entry to PREAMBLE; carrier runs over the whole busy span.
    ask_bit_timer #(
        .SPB          (SPB),
        .CARRIER_HALF (CARRIER_HALF)
    ) u_timer (
        .clk_i       (clk),
        .rst_ni      (rst),
        .bit_clr_i   (!is_bit_state(state_q) || abort),
        .car_clr_i   ((state_q == ST_IDLE) || abort),
        .bit_start_o (bit_start),
        .bit_end_o   (bit_end),
        .carrier_o   (carrier)
    );

    assign sync_shift = SYNC_WORD << bit_idx_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        n_words_d  = n_words_q;
        word_cnt_d = word_cnt_q;
        seen_d     = seen_q;
        tx_d       = tx_q;
        mod_load   = 1'b0;
        mod_ce     = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEED;
                    n_words_d  = n_words;
                    word_cnt_d = '0;
                end
            end
            ST_SEED: state_d = ST_LOAD;
            ST_LOAD: begin
                mod_load  = 1'b1;
                mod_ce    = 1'b1;
                bit_idx_d = '0;
                state_d   = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (bit_start) tx_d = ~bit_idx_q[0];
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(PREAMBLE_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = ST_SYNC;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SYNC: begin
                if (bit_start) tx_d = sync_shift[WORD_W-1];
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(WORD_W - 1)) begin
                        bit_idx_d = '0;
                        seen_d    = 1'b0;
                        state_d   = (n_words_q == '0) ? ST_GUARD : ST_ALIGN;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_ALIGN: begin
                // Keep stepping until the modulator reports a word edge, then
                // the next step lands on the first bit of a fresh word.
                if (bit_start) begin
                    tx_d = 1'b0;
                    if (mod_new_word) seen_d = 1'b1;
                end
                if (bit_end) begin
                    mod_ce = 1'b1;
                    if (seen_q) state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (bit_start) begin
                    tx_d = mod_bit;
                    if (mod_new_word && (word_cnt_q != '1)) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
                if (bit_end) begin
                    mod_ce = 1'b1;
                    if (word_cnt_q >= n_words_q) begin
                        bit_idx_d = '0;
                        state_d   = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (bit_start) tx_d = 1'b0;
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(GUARD_BITS - 1)) begin
                        frame_done = 1'b1;
                        bit_idx_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            bit_idx_d  = '0;
            word_cnt_d = '0;
            seen_d     = 1'b0;
            tx_d       = 1'b0;
            mod_load   = 1'b0;
            mod_ce     = 1'b0;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            n_words_q  <= '0;
            word_cnt_q <= '0;
            seen_q     <= 1'b0;
            tx_q       <= 1'b0;
            ask_q      <= 1'b0;
            mod_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            n_words_q  <= n_words_d;
            word_cnt_q <= word_cnt_d;
            seen_q     <= seen_d;
            tx_q       <= tx_d;
            ask_q      <= abort ? 1'b0 : (tx_q & carrier);
            mod_rst_q  <= (state_d != ST_SEED);
        end
    end

    assign mod_rst  = mod_rst_q;
    assign tx_bit   = tx_q;
    assign ask_out  = ask_q;
    assign busy     = (state_q != ST_IDLE);
    assign word_cnt = word_cnt_q;

endmodule
